// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared widths, access-size and FSM encodings, and
// small decode helpers for the MEM-stage data-memory access unit.
//   DATA_WIDTH / ADDR_WIDTH : default data path and byte-address widths
//   BE_WIDTH                : byte enables per data word
//   size_e                  : access size decoded from funct3[1:0]
//   state_e                 : access FSM states
package mem_access_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_REQ    = 2'b01,
        S_WAIT_R = 2'b10,
        S_DONE   = 2'b11
    } state_e;

    // funct3[1:0]: 00 byte, 01 half, 1x word. funct3[2] (signedness) is
    // the load data unit's business.
    function automatic size_e decode_size(input logic [1:0] f);
        case (f)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/response bus.
//   DMem_Req/DMem_Ready : request handshake (held stable until Ready)
//   DMem_We, DMem_Addr, DMem_BE, DMem_WData : request fields
//   DMem_RValid/DMem_RData : read response
// master = access unit, slave = data memory.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                    DMem_Req;
    logic                    DMem_Ready;
    logic                    DMem_We;
    logic [ADDR_WIDTH-1:0]   DMem_Addr;
    logic [DATA_WIDTH/8-1:0] DMem_BE;
    logic [DATA_WIDTH-1:0]   DMem_WData;
    logic                    DMem_RValid;
    logic [DATA_WIDTH-1:0]   DMem_RData;

    modport master (
        output DMem_Req, DMem_We, DMem_Addr, DMem_BE, DMem_WData,
        input  DMem_Ready, DMem_RValid, DMem_RData
    );

    modport slave (
        input  DMem_Req, DMem_We, DMem_Addr, DMem_BE, DMem_WData,
        output DMem_Ready, DMem_RValid, DMem_RData
    );
endinterface

// File: rtl/mem_access_unit_store_align.sv
// store_align: purely combinational store lane alignment.
//   size   : access size
//   offset : byte offset addr[1:0]
//   data   : rs2 value
//   be     : byte enables for the addressed lanes
//   wdata  : store data replicated across all lanes so memory can pick
//            the enabled ones without a shifter
module store_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = mem_access_unit_pkg::DATA_WIDTH
) (
    input  size_e                   size,
    input  logic [1:0]              offset,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   wdata
);
    localparam int LANES = DATA_WIDTH / 8;

    always_comb begin
        be    = '1;
        wdata = data;
        case (size)
            SZ_BYTE: begin
                be    = LANES'(1) << offset;
                wdata = {LANES{data[7:0]}};
            end
            SZ_HALF: begin
                be    = LANES'(3) << {offset[1], 1'b0};
                wdata = {(LANES/2){data[15:0]}};
            end
            default: begin
                be    = '1;
                wdata = data;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Checks alignment, runs the
// request/response handshake with data memory and stalls the pipeline
// until the access completes.
//   clk, rst_n        : clock, async active-low reset
//   MEM_MemRead/Write : access request from EX/MEM (write wins)
//   MEM_Funct3        : access size in [1:0]
//   MEM_Addr          : byte address
//   MEM_Store_Data    : rs2 value
//   dmem              : data-memory bus (master side)
//   Mem_R_Data        : read word shifted down to the addressed byte
//   Mem_Stall         : freeze IF..MEM
//   Misalign_Exc      : one-cycle misaligned-access flag (in DONE)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = mem_access_unit_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_access_unit_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MEM_MemRead,
    input  logic                  MEM_MemWrite,
    input  logic [2:0]            MEM_Funct3,
    input  logic [ADDR_WIDTH-1:0] MEM_Addr,
    input  logic [DATA_WIDTH-1:0] MEM_Store_Data,
    mem_access_unit_if.master     dmem,
    output logic [DATA_WIDTH-1:0] Mem_R_Data,
    output logic                  Mem_Stall,
    output logic                  Misalign_Exc
);
    localparam int BEW = DATA_WIDTH / 8;

    state_e     state;
    logic       store_q;
    logic [1:0] off_q;

    logic                  access;
    size_e                 size;
    logic                  misaligned;
    logic [BEW-1:0]        sa_be;
    logic [DATA_WIDTH-1:0] sa_wdata;

    // funct3[2] only selects sign extension downstream.
    logic unused_ok;
    assign unused_ok = MEM_Funct3[2];

    assign access     = MEM_MemRead | MEM_MemWrite;
    assign size       = decode_size(MEM_Funct3[1:0]);
    assign misaligned = is_misaligned(size, MEM_Addr[1:0]);

    store_align #(.DATA_WIDTH(DATA_WIDTH)) u_store_align (
        .size   (size),
        .offset (MEM_Addr[1:0]),
        .data   (MEM_Store_Data),
        .be     (sa_be),
        .wdata  (sa_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            store_q         <= 1'b0;
            off_q           <= 2'b00;
            dmem.DMem_Req   <= 1'b0;
            dmem.DMem_We    <= 1'b0;
            dmem.DMem_Addr  <= '0;
            dmem.DMem_BE    <= '0;
            dmem.DMem_WData <= '0;
            Mem_R_Data      <= '0;
            Misalign_Exc    <= 1'b0;
        end else begin
            Misalign_Exc <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            Misalign_Exc <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            dmem.DMem_Req   <= 1'b1;
                            dmem.DMem_We    <= MEM_MemWrite;
                            dmem.DMem_Addr  <= {MEM_Addr[ADDR_WIDTH-1:2], 2'b00};
                            dmem.DMem_BE    <= MEM_MemWrite ? sa_be : '1;
                            dmem.DMem_WData <= MEM_MemWrite ? sa_wdata : '0;
                            store_q         <= MEM_MemWrite;
                            off_q           <= MEM_Addr[1:0];
                            state           <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem.DMem_Ready) begin
                        dmem.DMem_Req <= 1'b0;
                        dmem.DMem_We  <= 1'b0;
                        state         <= store_q ? S_DONE : S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (dmem.DMem_RValid) begin
                        Mem_R_Data <= dmem.DMem_RData >> {off_q, 3'b000};
                        state      <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Mem_Stall = 1'b0;
        case (state)
            S_IDLE:   Mem_Stall = access;
            S_REQ:    Mem_Stall = 1'b1;
            S_WAIT_R: Mem_Stall = 1'b1;
            default:  Mem_Stall = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] sdata = 32'b0;
    logic [31:0] r_data;
    logic        stall;
    logic        exc;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rd = 32'h0;   // model of the last captured load value

    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MEM_MemRead    (mem_read),
        .MEM_MemWrite   (mem_write),
        .MEM_Funct3     (funct3),
        .MEM_Addr       (addr),
        .MEM_Store_Data (sdata),
        .dmem           (bus),
        .Mem_R_Data     (r_data),
        .Mem_Stall      (stall),
        .Misalign_Exc   (exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        return f[1] ? 4 : (f[0] ? 2 : 1);
    endfunction

    function automatic logic [3:0] ref_be(input bit st, input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        if (!st) return 4'hF;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] f, input logic [31:0] d);
        case (nbytes(f))
            1:       return {24'h0, d[7:0]} * 32'h0101_0101;
            2:       return {16'h0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        bus.DMem_Ready = 0;
        bus.DMem_RValid = 1'($urandom_range(0, 1));
        bus.DMem_RData = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req", 32'(bus.DMem_Req), 32'd0);
        chk("idle_exc", 32'(exc), 32'd0);
        chk("idle_rdata", r_data, exp_rd);
    endtask

    // One full access from the IDLE cycle through DONE. Ready comes after
    // rdy_dly extra REQ cycles; RValid after rv_dly extra WAIT_R cycles.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input int rdy_dly, input int rv_dly, input logic [31:0] rdat);
        bit   st  = wr;
        int   n   = nbytes(f);
        bit   mis = (a % n) != 0;
        logic [31:0] e_addr = a - (a % 4);
        logic [3:0]  e_be = ref_be(st, f, a);
        logic [31:0] e_wd = ref_wd(f, d);
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f; addr = a; sdata = d;
        bus.DMem_Ready = 0; bus.DMem_RValid = 0;
        #1;
        chk("idle_access_stall", 32'(stall), 32'd1);
        chk("idle_access_req", 32'(bus.DMem_Req), 32'd0);
        if (mis) begin
            @(negedge clk); #1;
            chk("mis_exc", 32'(exc), 32'd1);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_req", 32'(bus.DMem_Req), 32'd0);
            chk("mis_rdata", r_data, exp_rd);
            return;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            @(negedge clk);
            bus.DMem_Ready = (k == rdy_dly);
            bus.DMem_RValid = 1'($urandom_range(0, 1));  // must be ignored in REQ
            bus.DMem_RData = $urandom;
            #1;
            chk("req_req", 32'(bus.DMem_Req), 32'd1);
            chk("req_we", 32'(bus.DMem_We), 32'(st));
            chk("req_addr", bus.DMem_Addr, e_addr);
            chk("req_be", 32'(bus.DMem_BE), 32'(e_be));
            if (st) chk("req_wdata", bus.DMem_WData, e_wd);
            chk("req_stall", 32'(stall), 32'd1);
        end
        if (!st) begin
            for (int k = 0; k <= rv_dly; k++) begin
                @(negedge clk);
                bus.DMem_Ready = 1'($urandom_range(0, 1));   // ignored outside REQ
                bus.DMem_RValid = (k == rv_dly);
                bus.DMem_RData = (k == rv_dly) ? rdat : $urandom;
                #1;
                chk("wait_req", 32'(bus.DMem_Req), 32'd0);
                chk("wait_stall", 32'(stall), 32'd1);
            end
            exp_rd = rdat >> (8 * (a % 4));
        end
        @(negedge clk);
        bus.DMem_Ready = 0;
        bus.DMem_RValid = 1'($urandom_range(0, 1));
        bus.DMem_RData = $urandom;
        #1;
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(bus.DMem_Req), 32'd0);
        chk("done_exc", 32'(exc), 32'd0);
        chk("done_rdata", r_data, exp_rd);
    endtask

    initial begin
        bus.DMem_Ready = 0; bus.DMem_RValid = 0; bus.DMem_RData = 0;
        #2;
        chk("rst_req", 32'(bus.DMem_Req), 32'd0);
        chk("rst_we", 32'(bus.DMem_We), 32'd0);
        chk("rst_addr", bus.DMem_Addr, 32'd0);
        chk("rst_be", 32'(bus.DMem_BE), 32'd0);
        chk("rst_wdata", bus.DMem_WData, 32'd0);
        chk("rst_rdata", r_data, 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        @(negedge clk); rst_n = 1;
        idle_cycle();

        // SW, immediate Ready
        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        // SB to 0x203, Ready after 3 wait cycles
        access(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 3, 0, 0);
        // LH from 0x302, RValid two cycles after handshake
        access(1, 0, 3'b001, 32'h302, 32'h0, 0, 1, 32'h8001_1234);
        chk("lh_value", r_data, 32'h0000_8001);
        // misaligned LW
        access(1, 0, 3'b010, 32'h105, 32'h0, 0, 0, 0);
        idle_cycle();
        // read and write both set: store wins
        access(1, 1, 3'b010, 32'h40, 32'h1234_5678, 1, 0, 0);
        chk("rw_store_keeps_rdata", r_data, 32'h0000_8001);

        // reset while waiting for read data
        @(negedge clk);
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk); bus.DMem_Ready = 1;
        @(negedge clk); bus.DMem_Ready = 0;
        #1 chk("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 0; mem_read = 0; exp_rd = 0;
        #1;
        chk("mid_rst_req", 32'(bus.DMem_Req), 32'd0);
        chk("mid_rst_addr", bus.DMem_Addr, 32'd0);
        chk("mid_rst_be", 32'(bus.DMem_BE), 32'd0);
        chk("mid_rst_rdata", r_data, 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        @(negedge clk); rst_n = 1;
        bus.DMem_RValid = 1; bus.DMem_RData = 32'hCAFE_F00D;
        @(negedge clk); bus.DMem_RValid = 0;
        #1 chk("late_rvalid_ignored", r_data, 32'd0);
        access(0, 1, 3'b010, 32'h500, 32'hA5A5_0F0F, 0, 0, 0);

        // randomized accesses against the model
        for (int i = 0; i < 60; i++) begin
            bit rd, wr;
            int kind = $urandom_range(0, 2);
            rd = (kind != 1);
            wr = (kind != 0);
            access(rd, wr, 3'($urandom), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
